div_bcd_formatter: RTL and testbench

- Downstream stage of the 8-bit/4-bit divider. Takes one quotient/remainder pair and converts both to 3-digit packed BCD for the display/report stage.
- Uses sequential shift-add-3 (double dabble), one bit per clock.
- Valid/ready handshake on the input side and on the output side.

---
 rtl/div_bcd_formatter_if.sv | 27 ++
 rtl/div_bcd_formatter.sv | 167 ++++++++++++++++
 tb/tb_div_bcd_formatter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_bcd_formatter_if.sv
// Handshake bundle for div_bcd_formatter: divider result in, packed BCD out.
// master = producer/consumer side (testbench or neighbours), slave = the formatter.
interface div_bcd_formatter_if;
  // Both sides use strict valid/ready. A transfer happens on a rising edge
  // where valid && ready. Once valid is raised, it and its data stay stable
  // until that edge. ready may change freely and is never computed from valid.
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic [3:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] q_bcd;
  logic [11:0] r_bcd;
  logic        err;

  modport master (
    output in_valid, q, r, divisor, out_ready,
    input  in_ready, out_valid, q_bcd, r_bcd, err
  );

  modport slave (
    input  in_valid, q, r, divisor, out_ready,
    output in_ready, out_valid, q_bcd, r_bcd, err
  );
endinterface

// File: rtl/div_bcd_formatter.sv
// Converts a divider quotient/remainder pair to 3-digit packed BCD by serial double dabble.
// Optional macro DIVZERO_CHECK_EN: a zero divisor yields a 12'hFFF/err=1 marker after one edge.
module div_bcd_formatter #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  div_bcd_formatter_if.slave  bus,
  output logic [1:0]          dbg_state
);

  localparam int BW   = 4 * DIGITS;
  localparam int WORK = BW + W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [WORK-1:0]   q_work;
  logic [WORK-1:0]   r_work;
  logic [WORK-1:0]   q_next;
  logic [WORK-1:0]   r_next;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [BW-1:0]     q_bcd_r;
  logic [BW-1:0]     r_bcd_r;
  logic              err_r;

  // One double-dabble step: correct every BCD nibble >= 5 using the
  // pre-shift value, then shift the whole register left by one.
  function automatic logic [WORK-1:0] dd_step(input logic [WORK-1:0] v);
    logic [WORK-1:0] t;
    t = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[W+4*d +: 4] >= 4'd5)
        t[W+4*d +: 4] = t[W+4*d +: 4] + 4'd3;
    end
    return {t[WORK-2:0], 1'b0};
  endfunction

  assign q_next = dd_step(q_work);
  assign r_next = dd_step(r_work);

`ifdef DIVZERO_CHECK_EN
  logic dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      q_work      <= '0;
      r_work      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_bcd_r     <= '0;
      r_bcd_r     <= '0;
      err_r       <= 1'b0;
      dz          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_work     <= {{BW{1'b0}}, bus.q};
            r_work     <= {{BW{1'b0}}, bus.r};
            cnt        <= 3'd0;
            dz         <= (bus.divisor == 4'd0);
            in_ready_r <= 1'b0;
            state      <= CONV;
          end
        end
        CONV: begin
          // A zero divisor spends exactly one edge here and emits the marker.
          if (dz) begin
            q_bcd_r     <= '1;
            r_bcd_r     <= '1;
            err_r       <= 1'b1;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            q_work <= q_next;
            r_work <= r_next;
            cnt    <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              q_bcd_r     <= q_next[WORK-1:W];
              r_bcd_r     <= r_next[WORK-1:W];
              err_r       <= 1'b0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else
  logic unused_divisor;
  assign unused_divisor = ^bus.divisor;
  assign err_r          = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      q_work      <= '0;
      r_work      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_bcd_r     <= '0;
      r_bcd_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            q_work     <= {{BW{1'b0}}, bus.q};
            r_work     <= {{BW{1'b0}}, bus.r};
            cnt        <= 3'd0;
            in_ready_r <= 1'b0;
            state      <= CONV;
          end
        end
        CONV: begin
          q_work <= q_next;
          r_work <= r_next;
          cnt    <= cnt + 3'd1;
          // After the eighth shift all input bits sit in the BCD field.
          if (cnt == 3'd7) begin
            q_bcd_r     <= q_next[WORK-1:W];
            r_bcd_r     <= r_next[WORK-1:W];
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q_bcd     = q_bcd_r;
  assign bus.r_bcd     = r_bcd_r;
  assign bus.err       = err_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Self-checking bench for div_bcd_formatter: directed scenarios plus a randomized sweep
// of every quotient value against a decimal-digit reference model.
module tb_div_bcd_formatter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_state;
  int n_tests = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  div_bcd_formatter_if bus();

  div_bcd_formatter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Reference: three decimal digits of v, packed hundreds/tens/ones.
  function automatic logic [11:0] bcd3(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Driver: present one pair for a single edge, then scramble the inputs and
  // count edges until out_valid (-1 if it never comes). held reports whether
  // q_bcd/r_bcd kept their previous value until the result appeared.
  task automatic send(input logic [7:0] qv, input logic [7:0] rv, input logic [3:0] dv,
                      output int lat, output bit held);
    logic [11:0] q0, r0;
    q0 = bus.q_bcd;
    r0 = bus.r_bcd;
    held = 1'b1;
    bus.in_valid = 1'b1;
    bus.q = qv;
    bus.r = rv;
    bus.divisor = dv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.q = 8'($urandom);
    bus.r = 8'($urandom);
    bus.divisor = 4'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bus.q_bcd !== q0 || bus.r_bcd !== r0) held = 1'b0;
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.q = 8'd0;
    bus.r = 8'd0;
    bus.divisor = 4'd1;
    rst_n = 1'b0;
    #22;
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got ready/valid/err=%b want 100", {bus.in_ready, bus.out_valid, bus.err});
    end
    n_tests++;
    if ({bus.q_bcd, bus.r_bcd} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h want 000/000", bus.q_bcd, bus.r_bcd);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    bit held;
    bus.out_ready = 1'b1;
    send(8'd6, 8'd1, 4'd2, lat, held);
    n_tests++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 8", lat);
    end
    n_tests++;
    if ({bus.q_bcd, bus.r_bcd, bus.err} !== {12'h006, 12'h001, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_value: got %h/%h err=%b want 006/001 err=0", bus.q_bcd, bus.r_bcd, bus.err);
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL basic_hold: outputs changed during conversion, got 0 want 1");
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_release: got valid/ready=%b want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit held;
    bus.out_ready = 1'b1;
    send(8'd255, 8'd0, 4'd1, lat, held);
    n_tests++;
    if (lat !== 8 || {bus.q_bcd, bus.r_bcd} !== {12'h255, 12'h000}) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d %h/%h want lat=8 255/000", lat, bus.q_bcd, bus.r_bcd);
    end
    @(posedge clk); #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b want 1", bus.in_ready);
    end
    send(8'd100, 8'd99, 4'd2, lat, held);
    n_tests++;
    if (lat !== 8 || {bus.q_bcd, bus.r_bcd} !== {12'h100, 12'h099}) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d %h/%h want lat=8 100/099", lat, bus.q_bcd, bus.r_bcd);
    end
    n_tests++;
    if (!held) begin
      n_fail++;
      $display("FAIL b2b_hold: previous result not held during conversion, got 0 want 1");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sweep();
    int lat;
    bit held;
    logic [7:0] rv;
    logic [23:0] exp;
    bus.out_ready = 1'b1;
    for (int qv = 0; qv < 256; qv++) begin
      rv = 8'($urandom_range(0, 255));
      exp_q.push_back({bcd3(qv), bcd3(int'(rv))});
      send(8'(qv), rv, 4'($urandom_range(1, 15)), lat, held);
      exp = exp_q.pop_front();
      n_tests++;
      if (lat !== 8 || {bus.q_bcd, bus.r_bcd} !== exp || bus.err !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep q=%0d r=%0d: got lat=%0d %h/%h err=%b want lat=8 %h/%h err=0",
                 qv, rv, lat, bus.q_bcd, bus.r_bcd, bus.err, exp[23:12], exp[11:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit held;
    bus.out_ready = 1'b0;
    send(8'd3, 8'd3, 4'd4, lat, held);
    n_tests++;
    if (lat !== 8 || {bus.q_bcd, bus.r_bcd} !== {12'h003, 12'h003}) begin
      n_fail++;
      $display("FAIL bp_result: got lat=%0d %h/%h want lat=8 003/003", lat, bus.q_bcd, bus.r_bcd);
    end
    bus.in_valid = 1'b1;
    bus.q = 8'd9;
    bus.r = 8'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({bus.out_valid, bus.in_ready, bus.q_bcd, bus.r_bcd} !== {2'b10, 12'h003, 12'h003}) begin
        n_fail++;
        $display("FAIL bp_stall cycle %0d: got valid/ready=%b %h/%h want 10 003/003",
                 i, {bus.out_valid, bus.in_ready}, bus.q_bcd, bus.r_bcd);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready, bus.q_bcd} !== {2'b01, 12'h003}) begin
      n_fail++;
      $display("FAIL bp_release: got valid/ready=%b q=%h want 01 003", {bus.out_valid, bus.in_ready}, bus.q_bcd);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_ignored: stalled request was taken, got valid/ready=%b want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit held;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.q = 8'd200;
    bus.r = 8'd7;
    bus.divisor = 4'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready, bus.q_bcd, bus.r_bcd} !== {2'b01, 24'h0}) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got valid/ready=%b %h/%h want 01 000/000",
               {bus.out_valid, bus.in_ready}, bus.q_bcd, bus.r_bcd);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got valid/ready=%b want 01", {bus.out_valid, bus.in_ready});
    end
    send(8'd42, 8'd5, 4'd3, lat, held);
    n_tests++;
    if (lat !== 8 || {bus.q_bcd, bus.r_bcd} !== {12'h042, 12'h005}) begin
      n_fail++;
      $display("FAIL rst_mid_fresh: got lat=%0d %h/%h want lat=8 042/005", lat, bus.q_bcd, bus.r_bcd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_divzero();
    int lat;
    bit held;
    bus.out_ready = 1'b1;
    send(8'hFF, 8'h00, 4'd0, lat, held);
`ifdef DIVZERO_CHECK_EN
    n_tests++;
    if (lat !== 1 || {bus.q_bcd, bus.r_bcd, bus.err} !== {12'hFFF, 12'hFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL divzero_marker: got lat=%0d %h/%h err=%b want lat=1 FFF/FFF err=1",
               lat, bus.q_bcd, bus.r_bcd, bus.err);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.err} !== 2'b01) begin
      n_fail++;
      $display("FAIL divzero_hold: got valid/err=%b want 01", {bus.out_valid, bus.err});
    end
`else
    n_tests++;
    if (lat !== 8 || {bus.q_bcd, bus.r_bcd, bus.err} !== {12'h255, 12'h000, 1'b0}) begin
      n_fail++;
      $display("FAIL divzero_ignored: got lat=%0d %h/%h err=%b want lat=8 255/000 err=0",
               lat, bus.q_bcd, bus.r_bcd, bus.err);
    end
    @(posedge clk); #1;
`endif
    send(8'd17, 8'd3, 4'd5, lat, held);
    n_tests++;
    if (lat !== 8 || {bus.q_bcd, bus.r_bcd, bus.err} !== {12'h017, 12'h003, 1'b0}) begin
      n_fail++;
      $display("FAIL divzero_after: got lat=%0d %h/%h err=%b want lat=8 017/003 err=0",
               lat, bus.q_bcd, bus.r_bcd, bus.err);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sweep();
    test_backpressure();
    test_reset_mid();
    test_divzero();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
